spi_prog_loader: RTL and testbench
==================================

// Module: spi_prog_loader
// PURPOSE
//  Serial front end of the tiny processor. Deserialises master frames on MOSI into
//  8-bit data + 4-bit address words. Issues one-cycle write strobes to the
//  instruction cache (CSI_N low) or the data cache (CSD_N low).
//  Sits between the uio pins and the cache write ports. Owns frame validation.
// PARAMETERS
//  DATA_W    8   payload bits per frame (cache word width)
//  ADDR_W    4   address bits per frame
//  DMEM_SZ   15  data-cache depth; dmem address >= DMEM_SZ is rejected
// PORTS
//  clk        in   1       clock; master drives MOSI synchronous to clk (sclk = clk)
//  rst        in   1       synchronous, active-high reset
//  proc_en    in   1       processor running; loader held idle while high
//  csi_n      in   1       select icache target, active low
//  csd_n      in   1       select dcache target, active low
//  mosi       in   1       serial data, MSB first: data[7:0] then addr[3:0]
//  err_clr    in   1       one-cycle clear of err_code
//  wr_data    out  DATA_W  registered payload of last accepted frame
//  wr_addr    out  ADDR_W  registered address of last accepted frame
//  imem_we    out  1       one-cycle icache write strobe
//  dmem_we    out  1       one-cycle dcache write strobe
//  busy       out  1       high when state != IDLE
//  err_code   out  2       sticky: 0 none, 1 short frame, 2 collision/range, 3 parity
// BEHAVIOUR
//  Reset: state IDLE, bit counter 0, wr_data/wr_addr 0, strobes 0, busy 0, err_code 0.
//  FSM states:
//   IDLE  -> SHIFT  exactly one of csi_n/csd_n low and proc_en low. Target latched;
//                   mosi sampled as bit 0 in the same cycle.
//   SHIFT           one bit per clk into the shift register; counter 0..FRAME_LEN-1.
//                   FRAME_LEN = DATA_W+ADDR_W (=12).
//   SHIFT -> IDLE   select released with counter != 0: frame discarded, err_code=1.
//   SHIFT           on the last bit, frame complete:
//                   - copy to wr_data/wr_addr; strobe target next cycle (latency 1).
//                   - counter wraps to 0, same target; next frame may start immediately.
//                   - back-to-back frames: 1 strobe per 12 clks.
//   SHIFT -> IDLE   select released with counter == 0 (frame boundary): clean exit.
//   any   -> HOLD   both selects low: collision, err_code=2, no strobe.
//   SHIFT -> HOLD   dcache frame with addr >= DMEM_SZ (addr 15): err_code=2, no strobe.
//                   wr_* still updated.
//   HOLD  -> IDLE   both selects high.
//  proc_en high forces IDLE next cycle from any state. Partial frame is discarded
//   without error; strobes suppressed that cycle.
//  Select switch mid-frame (csi_n->high, csd_n->low same clk): treated as release
//   (err_code=1), then a fresh IDLE->SHIFT on the following cycle.
//  err_code: first error wins; holds until rst or err_clr. An error in the same
//   cycle as err_clr is recorded.
//  imem_we and dmem_we are never high together. Strobes are 0 during rst.
// CONFIGURATION
//  LOADER_PARITY_EN defined:
//   - FRAME_LEN = 13; bit 12 is odd parity over the 12 payload bits.
//   - mismatch: no strobe, err_code=3, go to HOLD.
//   - wr_* are not updated on a parity fail.
//  LOADER_PARITY_EN undefined: FRAME_LEN = 12, no parity logic, err_code never 3.
// STRUCTURE
//  Shared header tiny_proc_defs.vh holds:
//   - DATAPATH_W, frame widths, DMEM_SZ
//   - loader state encodings (IDLE/SHIFT/HOLD)
//   - err_code values
//  Sub-module frame_shifter: parameterised MSB-first shift register + bit counter.
//   Outputs last_bit and the parallel word. FSM and checks stay in the top.
// TESTING
//  - csi_n low 12 clks, bits 0xA5 then 0x3 -> imem_we 1 clk after 12th bit.
//    wr_data=0xA5, wr_addr=0x3, err_code=0.
//  - csd_n low 24 clks: frames (0x11,0x2), (0x22,0x4) -> two dmem_we pulses 12 clks apart.
//    Correct data/addr on each pulse.
//  - csd_n frame (0x7F, addr 0xF) -> no dmem_we, err_code=2.
//    Releases to IDLE after csd_n high.
//  - csi_n released after 5 bits -> no strobe, err_code=1.
//    err_clr -> err_code=0; next full frame is accepted.
//  - both selects low -> err_code=2, no strobes.
//    proc_en high mid-frame -> IDLE, busy=0, no strobe, err_code unchanged.
//  - LOADER_PARITY_EN: frame 0xFF/0x0 with parity 0 -> accepted.
//    Parity 1 -> err_code=3, no strobe.

Source files
------------

// File: rtl/spi_prog_loader_pkg.sv
// Shared definitions for the SPI program loader: frame geometry, data-cache
// depth, loader state encodings and error codes.
// Optional feature macro: LOADER_PARITY_EN (adds a trailing odd-parity bit).
package spi_prog_loader_pkg;

    localparam int DATAPATH_W = 8;
    localparam int DATA_W     = DATAPATH_W;
    localparam int ADDR_W     = 4;
    localparam int PAYLOAD_W  = DATA_W + ADDR_W;
    localparam int DMEM_SZ    = 15;

`ifdef LOADER_PARITY_EN
    localparam int FRAME_LEN  = PAYLOAD_W + 1;
`else
    localparam int FRAME_LEN  = PAYLOAD_W;
`endif

    localparam int CNT_W      = $clog2(FRAME_LEN);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_SHORT  = 2'd1;
    localparam logic [1:0] ERR_COLL   = 2'd2;
    localparam logic [1:0] ERR_PARITY = 2'd3;

    // Parity bit the master appends: XOR of all payload bits.
    function automatic logic odd_parity(input logic [PAYLOAD_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/spi_prog_loader_frame_shifter.sv
// MSB-first serial-to-parallel shifter with a wrapping bit counter.
// word_o includes the bit being sampled this cycle, so the owner can
// capture a complete frame on the same edge that takes the last bit.
module spi_prog_loader_frame_shifter #(
    parameter int W  = 12,
    parameter int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          shift_en_i,
    input  logic          bit_i,
    output logic [W-1:0]  word_o,
    output logic          last_bit_o,
    output logic [CW-1:0] cnt_o
);

    logic [W-2:0]  shift_q;
    logic [CW-1:0] cnt_q;

    assign word_o     = {shift_q, bit_i};
    assign last_bit_o = (cnt_q == CW'(W - 1));
    assign cnt_o      = cnt_q;

    // Shift register: takes one bit per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else if (shift_en_i) begin
            shift_q <= {shift_q[W-3:0], bit_i};
        end
    end

    // Bit counter: wraps at the frame boundary, cleared whenever not shifting.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (shift_en_i) begin
            cnt_q <= last_bit_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/spi_prog_loader.sv
// Serial front end of the tiny processor: deserialises MOSI frames
// (data MSB first, then address) and issues one-cycle write strobes to the
// instruction or data cache. Owns frame validation and the sticky error code.
// Optional feature macro: LOADER_PARITY_EN (13-bit frames, trailing parity).
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | waiting for exactly one select low with proc_en low
//  ST_SHIFT | receiving bits for the latched target, frames back-to-back
//  ST_HOLD  | error parked until both selects are released
module spi_prog_loader
    import spi_prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              proc_en_i,
    input  logic              csi_n_i,
    input  logic              csd_n_i,
    input  logic              mosi_i,
    input  logic              err_clr_i,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              imem_we_o,
    output logic              dmem_we_o,
    output logic              busy_o,
    output logic [1:0]        err_code_o
);

    localparam logic [ADDR_W-1:0] DMEM_LIMIT = ADDR_W'(DMEM_SZ);

    logic [1:0]           state_q, state_d;
    logic                 tgt_q, tgt_d;           // 1 = data cache
    logic [1:0]           err_q, err_d, err_new;
    logic [DATA_W-1:0]    wr_data_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic                 imem_we_q, dmem_we_q;
    logic                 strobe, accept, shift_en, shift_clr;
    logic [FRAME_LEN-1:0] word;
    logic                 last_bit;
    logic [CNT_W-1:0]     cnt;
    logic [PAYLOAD_W-1:0] payload;
    logic [DATA_W-1:0]    frame_data;
    logic [ADDR_W-1:0]    frame_addr;
    logic                 sel_i, sel_d, coll, tgt_low, frame_ok;

    assign sel_i      = ~csi_n_i &  csd_n_i;
    assign sel_d      =  csi_n_i & ~csd_n_i;
    assign coll       = ~csi_n_i & ~csd_n_i;
    assign tgt_low    = tgt_q ? ~csd_n_i : ~csi_n_i;

    assign payload    = word[FRAME_LEN-1 -: PAYLOAD_W];
    assign frame_data = payload[PAYLOAD_W-1 -: DATA_W];
    assign frame_addr = payload[ADDR_W-1:0];

`ifdef LOADER_PARITY_EN
    assign frame_ok   = (word[0] == odd_parity(payload));
`else
    assign frame_ok   = 1'b1;
`endif

    assign shift_clr  = (state_d != ST_SHIFT);

    spi_prog_loader_frame_shifter #(
        .W  (FRAME_LEN),
        .CW (CNT_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (shift_clr),
        .shift_en_i (shift_en),
        .bit_i      (mosi_i),
        .word_o     (word),
        .last_bit_o (last_bit),
        .cnt_o      (cnt)
    );

    // Next-state, shift control and frame-completion checks.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        shift_en = 1'b0;
        accept   = 1'b0;
        strobe   = 1'b0;
        err_new  = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (proc_en_i) begin
                    state_d = ST_IDLE;
                end else if (coll) begin
                    state_d = ST_HOLD;
                    err_new = ERR_COLL;
                end else if (sel_i || sel_d) begin
                    state_d  = ST_SHIFT;
                    tgt_d    = sel_d;
                    shift_en = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (proc_en_i) begin
                    state_d = ST_IDLE;
                end else if (coll) begin
                    state_d = ST_HOLD;
                    err_new = ERR_COLL;
                end else if (!tgt_low) begin
                    // Release (or select switch) ends the burst; mid-frame is an error.
                    state_d = ST_IDLE;
                    if (cnt != '0) begin
                        err_new = ERR_SHORT;
                    end
                end else begin
                    shift_en = 1'b1;
                    if (last_bit) begin
                        if (!frame_ok) begin
                            state_d = ST_HOLD;
                            err_new = ERR_PARITY;
                        end else begin
                            accept = 1'b1;
                            if (tgt_q && (frame_addr >= DMEM_LIMIT)) begin
                                state_d = ST_HOLD;
                                err_new = ERR_COLL;
                            end else begin
                                strobe = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (proc_en_i || (csi_n_i && csd_n_i)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky error: first error wins; a new error beats a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (err_clr_i) begin
            err_d = ERR_NONE;
        end
        if ((err_new != ERR_NONE) && ((err_q == ERR_NONE) || err_clr_i)) begin
            err_d = err_new;
        end
    end

    // FSM state, latched target and error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tgt_q   <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
        end
    end

    // Captured word and one-cycle cache write strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_data_q <= '0;
            wr_addr_q <= '0;
            imem_we_q <= 1'b0;
            dmem_we_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_data_q <= frame_data;
                wr_addr_q <= frame_addr;
            end
            imem_we_q <= strobe & ~tgt_q;
            dmem_we_q <= strobe &  tgt_q;
        end
    end

    assign wr_data_o  = wr_data_q;
    assign wr_addr_o  = wr_addr_q;
    assign imem_we_o  = imem_we_q;
    assign dmem_we_o  = dmem_we_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign err_code_o = err_q;

endmodule

// File: tb/tb_spi_prog_loader.sv
// Directed bench for spi_prog_loader. Expected strobes are queued by the
// stimulus; a negedge monitor pops and checks them, including the cycle.
module tb_spi_prog_loader;
    import spi_prog_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst, proc_en, csi_n, csd_n, mosi, err_clr;
    logic [7:0] wr_data;
    logic [3:0] wr_addr;
    logic       imem_we, dmem_we, busy;
    logic [1:0] err_code;

    typedef struct {
        bit         to_d;
        logic [7:0] data;
        logic [3:0] addr;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vec  = 0;
    int   miss = 0;
    int   cyc  = 0;

    spi_prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .proc_en_i  (proc_en),
        .csi_n_i    (csi_n),
        .csd_n_i    (csd_n),
        .mosi_i     (mosi),
        .err_clr_i  (err_clr),
        .wr_data_o  (wr_data),
        .wr_addr_o  (wr_addr),
        .imem_we_o  (imem_we),
        .dmem_we_o  (dmem_we),
        .busy_o     (busy),
        .err_code_o (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (imem_we === 1'b1 && dmem_we === 1'b1) begin
                vec++;
                miss++;
                $display("FAIL strobe_exclusive: imem_we=%b dmem_we=%b required not both", imem_we, dmem_we);
            end else if (imem_we === 1'b1 || dmem_we === 1'b1) begin
                vec++;
                if (exp_q.size() == 0) begin
                    miss++;
                    $display("FAIL unexpected_strobe: imem_we=%b dmem_we=%b data=%0h addr=%0h at cyc %0d, required none",
                             imem_we, dmem_we, wr_data, wr_addr, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (dmem_we !== e.to_d || wr_data !== e.data || wr_addr !== e.addr || cyc != e.cyc) begin
                        miss++;
                        $display("FAIL strobe_check: got dmem=%b data=%0h addr=%0h cyc=%0d, required dmem=%b data=%0h addr=%0h cyc=%0d",
                                 dmem_we, wr_data, wr_addr, cyc, e.to_d, e.data, e.addr, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        csi_n = 1'b1;
        csd_n = 1'b1;
        mosi  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    // Sends bits MSB first; the 13th bit is only sent when parity is enabled.
    task automatic send_frame(input bit to_d, input logic [7:0] d, input logic [3:0] a,
                              input bit expect_wr, input bit bad_par);
        logic [12:0] f13;
        f13 = {d, a, (^{d, a}) ^ bad_par};
        if (expect_wr) exp_q.push_back('{to_d, d, a, cyc + FRAME_LEN});
        for (int i = 12; i > 12 - FRAME_LEN; i--) begin
            csi_n = to_d;
            csd_n = !to_d;
            mosi  = f13[i];
            tick();
        end
        mosi = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; proc_en = 1'b0; csi_n = 1'b1; csd_n = 1'b1; mosi = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        chk("rst_imem_we", {31'd0, imem_we}, 0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 0);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err", {30'd0, err_code}, 0);
        chk("rst_wr_data", {24'd0, wr_data}, 0);
        chk("rst_wr_addr", {28'd0, wr_addr}, 0);

        // Single icache frame.
        send_frame(1'b0, 8'hA5, 4'h3, 1'b1, 1'b0);
        idle(2);
        chk("icache_err", {30'd0, err_code}, 0);
        chk("icache_busy", {31'd0, busy}, 0);

        // Back-to-back dcache frames, strobes 12 clocks apart.
        send_frame(1'b1, 8'h11, 4'h2, 1'b1, 1'b0);
        send_frame(1'b1, 8'h22, 4'h4, 1'b1, 1'b0);
        idle(2);

        // Out-of-range dcache address: no strobe, HOLD, wr_* updated.
        send_frame(1'b1, 8'h7F, 4'hF, 1'b0, 1'b0);
        chk("range_err", {30'd0, err_code}, 2);
        chk("range_busy", {31'd0, busy}, 1);
        chk("range_wr_data", {24'd0, wr_data}, 32'h7F);
        chk("range_wr_addr", {28'd0, wr_addr}, 32'hF);
        idle(1);
        chk("range_release_busy", {31'd0, busy}, 0);
        pulse_clr();
        chk("clr_err", {30'd0, err_code}, 0);

        // Highest legal dcache address.
        send_frame(1'b1, 8'hC3, 4'hE, 1'b1, 1'b0);
        idle(1);

        // Short frame: five bits then release.
        for (int i = 0; i < 5; i++) begin
            csi_n = 1'b0; mosi = i[0]; tick();
        end
        idle(1);
        chk("short_err", {30'd0, err_code}, 1);
        chk("short_busy", {31'd0, busy}, 0);

        // First error wins over a later collision.
        csi_n = 1'b0; csd_n = 1'b0; tick();
        chk("first_err_wins", {30'd0, err_code}, 1);
        idle(1);
        pulse_clr();
        chk("short_clr_err", {30'd0, err_code}, 0);
        send_frame(1'b0, 8'h5A, 4'hC, 1'b1, 1'b0);
        idle(1);

        // Collision.
        csi_n = 1'b0; csd_n = 1'b0;
        repeat (3) tick();
        chk("coll_err", {30'd0, err_code}, 2);
        chk("coll_busy", {31'd0, busy}, 1);
        idle(1);
        chk("coll_release_busy", {31'd0, busy}, 0);
        pulse_clr();

        // proc_en mid-frame: abort to IDLE, no strobe, no error.
        for (int i = 0; i < 6; i++) begin
            csi_n = 1'b0; mosi = 1'b1; tick();
        end
        proc_en = 1'b1;
        tick();
        chk("proc_en_busy", {31'd0, busy}, 0);
        tick();
        chk("proc_en_hold_busy", {31'd0, busy}, 0);
        chk("proc_en_err", {30'd0, err_code}, 0);
        proc_en = 1'b0;
        idle(2);

        // Select switch mid-frame: short-frame error, then fresh dcache frame.
        for (int i = 0; i < 4; i++) begin
            csi_n = 1'b0; mosi = 1'b1; tick();
        end
        csi_n = 1'b1; csd_n = 1'b0; tick();
        chk("switch_err", {30'd0, err_code}, 1);
        send_frame(1'b1, 8'h33, 4'h5, 1'b1, 1'b0);
        idle(1);

        // Error in the same cycle as err_clr is recorded.
        csi_n = 1'b0; csd_n = 1'b0; err_clr = 1'b1; tick();
        err_clr = 1'b0;
        chk("err_with_clr", {30'd0, err_code}, 2);
        idle(1);
        pulse_clr();

`ifdef LOADER_PARITY_EN
        send_frame(1'b0, 8'hFF, 4'h0, 1'b1, 1'b0);
        idle(1);
        chk("parity_good_err", {30'd0, err_code}, 0);
        send_frame(1'b0, 8'h12, 4'h3, 1'b0, 1'b1);
        chk("parity_bad_err", {30'd0, err_code}, 3);
        chk("parity_bad_wr_data", {24'd0, wr_data}, 32'hFF);
        chk("parity_bad_wr_addr", {28'd0, wr_addr}, 32'h0);
        idle(1);
        pulse_clr();
`endif

        idle(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
